// File: rtl/program_mem_banked.sv
// program_mem_banked: NUM_BANKS program images with registered fetch and drain/commit bank switching.
// Define PROGMEM_LOAD_EN to add the run-time load port; otherwise the banks are ROM.
module program_mem_banked #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BANK_DEPTH = 256,
  parameter int NUM_BANKS = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 16'hF000,
  parameter string INIT_PREFIX = "program_bank",
  localparam int BSEL_W = $clog2(NUM_BANKS) > 1 ? $clog2(NUM_BANKS) : 1,
  localparam int IDX_W = $clog2(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  fetch_valid,
  output logic                  fetch_oob,
`ifdef PROGMEM_LOAD_EN
  input  logic                  load_en,
  input  logic [BSEL_W-1:0]     load_bank,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
`endif
  input  logic                  mode_req_valid,
  input  logic [BSEL_W-1:0]     mode_req,
  output logic [BSEL_W-1:0]     mode_active,
  output logic                  mode_busy,
  output logic                  mode_done,
  output logic                  mode_err
);
  localparam logic [BSEL_W:0] NB = (BSEL_W+1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] BD = (ADDR_WIDTH+1)'(BANK_DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, COMMIT} state_t;
  state_t state, state_nxt;
  logic [BSEL_W-1:0] target;
  logic [DATA_WIDTH-1:0] rd [NUM_BANKS];
  logic req_ok, req_bad, oob, take;
  logic [IDX_W-1:0] idx;
  assign idx = fetch_addr[IDX_W-1:0];
  assign oob = {1'b0, fetch_addr} >= BD;
  assign req_ok = mode_req_valid && {1'b0, mode_req} < NB && mode_req != mode_active;
  assign req_bad = mode_req_valid && {1'b0, mode_req} >= NB;
  assign take = state == RUN && fetch_req;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] words [BANK_DEPTH];
    initial begin
      for (int w = 0; w < BANK_DEPTH; w++) words[w] = NOP_WORD;
    end
`ifdef PROGMEM_LOAD_EN
    always_ff @(posedge clk)
      if (load_en && load_bank == BSEL_W'(b) && {1'b0, load_addr} < BD)
        words[load_addr[IDX_W-1:0]] <= load_data;
`endif
    assign rd[b] = words[idx];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      target <= '0;
      mode_active <= '0;
      mode_done <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN && req_ok) target <= mode_req;
      if (state == COMMIT) mode_active <= target;
      mode_done <= state == COMMIT;
      mode_err <= state == RUN && req_bad;
    end
  always_comb
    state_nxt = state == RUN ? (req_ok ? DRAIN : RUN) : state == DRAIN ? COMMIT : RUN;
  always_comb
    mode_busy = state != RUN;
  // A fetch sampled together with an accepted switch still reads the old bank.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instruction <= NOP_WORD;
      fetch_valid <= 1'b0;
      fetch_oob <= 1'b0;
    end else begin
      fetch_valid <= take;
      fetch_oob <= take && oob;
      if (take) instruction <= oob ? NOP_WORD : rd[mode_active];
    end
endmodule

// File: tb/tb_program_mem_banked.sv
// tb_program_mem_banked: directed checks of fetch, bank switching, rejects, loads and mid-switch reset.
module tb_program_mem_banked;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_req = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic [15:0] instruction;
  logic fetch_valid, fetch_oob;
  logic mode_req_valid = 1'b0;
  logic [1:0] mode_req = '0;
  logic [1:0] mode_active;
  logic mode_busy, mode_done, mode_err;
`ifdef PROGMEM_LOAD_EN
  logic load_en = 1'b0;
  logic [1:0] load_bank = '0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  program_mem_banked #(.NUM_BANKS(3), .INIT_PREFIX("")) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instruction(instruction), .fetch_valid(fetch_valid), .fetch_oob(fetch_oob),
`ifdef PROGMEM_LOAD_EN
    .load_en(load_en), .load_bank(load_bank), .load_addr(load_addr), .load_data(load_data),
`endif
    .mode_req_valid(mode_req_valid), .mode_req(mode_req), .mode_active(mode_active),
    .mode_busy(mode_busy), .mode_done(mode_done), .mode_err(mode_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
`ifdef PROGMEM_LOAD_EN
  task automatic load(input logic [1:0] b, input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_bank = b; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask
`endif
  initial begin
    #1;
`ifdef PROGMEM_LOAD_EN
    load(2'd0, 16'd3, 16'h1234);
    load(2'd0, 16'd0, 16'h0A0A);
    load(2'd2, 16'd0, 16'h2222);
    load(2'd1, 16'd7, 16'h7777);
`else
    dut.g_bank[0].words[3] = 16'h1234;
    dut.g_bank[0].words[0] = 16'h0A0A;
    dut.g_bank[2].words[0] = 16'h2222;
    dut.g_bank[1].words[7] = 16'h7777;
    tick;
`endif
    check("rst_instr", instruction, 16'hF000);
    check("rst_valid", fetch_valid, 0);
    check("rst_active", mode_active, 0);
    rst_n = 1'b1;
    tick;
    check("idle_instr", instruction, 16'hF000);
    check("idle_valid", fetch_valid, 0);
    check("idle_busy", mode_busy, 0);
    check("idle_done", mode_done, 0);
    check("idle_err", mode_err, 0);
    fetch_req = 1'b1; fetch_addr = 16'h0100;
    tick;
    check("oob_instr", instruction, 16'hF000);
    check("oob_flag", fetch_oob, 1);
    check("oob_valid", fetch_valid, 1);
    fetch_addr = 16'd3;
    tick;
    check("f3_instr", instruction, 16'h1234);
    check("f3_valid", fetch_valid, 1);
    check("f3_oob", fetch_oob, 0);
    fetch_req = 1'b0;
    tick;
    check("hold_instr", instruction, 16'h1234);
    check("hold_valid", fetch_valid, 0);
    fetch_req = 1'b1; fetch_addr = 16'd0; mode_req_valid = 1'b1; mode_req = 2'd2;
    tick;
    check("sw_old_bank", instruction, 16'h0A0A);
    check("sw_n1_valid", fetch_valid, 1);
    check("sw_n1_busy", mode_busy, 1);
    check("sw_n1_active", mode_active, 0);
    mode_req_valid = 1'b0;
    tick;
    check("sw_n2_valid", fetch_valid, 0);
    check("sw_n2_busy", mode_busy, 1);
    check("sw_n2_done", mode_done, 0);
    fetch_req = 1'b0;
    tick;
    check("sw_n3_busy", mode_busy, 0);
    check("sw_n3_active", mode_active, 2);
    check("sw_n3_done", mode_done, 1);
    fetch_req = 1'b1;
    tick;
    check("new_bank", instruction, 16'h2222);
    check("new_valid", fetch_valid, 1);
    check("done_pulse", mode_done, 0);
    fetch_req = 1'b0; mode_req_valid = 1'b1; mode_req = 2'd2;
    tick;
    check("same_busy", mode_busy, 0);
    check("same_err", mode_err, 0);
    mode_req = 2'd3;
    tick;
    check("same_done", mode_done, 0);
    check("bad_err", mode_err, 1);
    check("bad_busy", mode_busy, 0);
    mode_req_valid = 1'b0;
    tick;
    check("bad_err_end", mode_err, 0);
    check("bad_active", mode_active, 2);
`ifdef PROGMEM_LOAD_EN
    mode_req_valid = 1'b1; mode_req = 2'd1;
    tick;
    mode_req_valid = 1'b0;
    tick;
    tick;
    check("ld_active", mode_active, 1);
    fetch_req = 1'b1; fetch_addr = 16'd7;
    load_en = 1'b1; load_bank = 2'd1; load_addr = 16'd7; load_data = 16'hBEEF;
    tick;
    check("rbw_old", instruction, 16'h7777);
    load_bank = 2'd3; load_addr = 16'd0; load_data = 16'hDEAD;
    tick;
    check("rbw_new", instruction, 16'hBEEF);
    load_bank = 2'd1; load_addr = 16'h0100;
    tick;
    load_en = 1'b0; fetch_addr = 16'd0;
    tick;
    check("drop_load", instruction, 16'hF000);
    fetch_req = 1'b0;
`endif
    mode_req_valid = 1'b1; mode_req = 2'd0;
    tick;
    mode_req_valid = 1'b0;
    check("drain_busy", mode_busy, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_active", mode_active, 0);
    check("mid_rst_busy", mode_busy, 0);
    rst_n = 1'b1;
    tick;
    check("mid_rst_done1", mode_done, 0);
    check("mid_rst_busy1", mode_busy, 0);
    tick;
    check("mid_rst_done2", mode_done, 0);
    check("mid_rst_active2", mode_active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
